// File: rtl/vector_sum_reduce_pkg.sv
// Shared types and sizing for the vector sum-reduction stage.
// Element type and vector width mirror the ARR/MAX_NEURONS library definitions.
package vector_sum_reduce_pkg;

  localparam int MAX_NEURONS = 16;
  localparam int ELEM_W      = 32;
  localparam int SEL_W       = $clog2(MAX_NEURONS);
  localparam int IDX_W       = SEL_W + 1;

  typedef logic signed [ELEM_W-1:0] elem_t;
  typedef elem_t [MAX_NEURONS-1:0]  arr_t;
  typedef logic [IDX_W-1:0]         len_t;
  typedef logic [SEL_W-1:0]         sel_t;

  // Effective element count: non-positive lengths sum nothing, oversize lengths sum everything.
  function automatic len_t eff_len(input logic signed [31:0] length);
    if (length <= 0)
      return '0;
    else if (length > MAX_NEURONS)
      return len_t'(MAX_NEURONS);
    else
      return len_t'(length);
  endfunction

endpackage

// File: rtl/vector_sum_reduce_sat_clamp.sv
// Combinational signed clamp from a wide accumulator to a narrower result,
// flagging when the clamp altered the value.
module sat_clamp #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 32
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    ovf
);

  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    dout = din[OUT_W-1:0];
    ovf  = 1'b0;
    if (din > MAX_V) begin
      dout = MAX_V[OUT_W-1:0];
      ovf  = 1'b1;
    end else if (din < MIN_V) begin
      dout = MIN_V[OUT_W-1:0];
      ovf  = 1'b1;
    end
  end

endmodule

// File: rtl/vector_sum_reduce.sv
// Sequential reduction: sums the first `length` elements of a vector, one per clock,
// and presents a saturated 32-bit result with zero/overflow flags for the divide stage.
module vector_sum_reduce
  import vector_sum_reduce_pkg::*;
#(
  parameter int ACC_W = 64
) (
  input  logic               CLK,
  input  logic               RST,
  input  arr_t               vector1,
  input  logic signed [31:0] length,
  input  logic               start,
  output logic               busy,
  output logic               valid,
  output logic signed [31:0] scalar,
  output logic signed [31:0] count,
  output logic               zero,
  output logic               ovf
);

  typedef enum logic [1:0] {IDLE, LOAD, ACCUM, DONE} state_t;

  state_t                   state, state_nxt;
  arr_t                     vec;
  len_t                     n;
  sel_t                     idx;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  fin_val;
  logic signed [31:0]       clamp_y;
  logic                     clamp_ovf;
  logic                     accept;
  logic                     last;
  logic                     finish;

  assign accept  = start && (state == IDLE || state == DONE);
  assign last    = (state == ACCUM) && ({1'b0, idx} == n - 1'b1);
  assign finish  = last || (state == LOAD && n == '0);
  assign acc_sum = acc + {{(ACC_W-ELEM_W){vec[idx][ELEM_W-1]}}, vec[idx]};
  // The final element is folded in on the same edge that registers the result.
  assign fin_val = (state == ACCUM) ? acc_sum : acc;

  sat_clamp #(
    .IN_W (ACC_W),
    .OUT_W(32)
  ) u_clamp (
    .din (fin_val),
    .dout(clamp_y),
    .ovf (clamp_ovf)
  );

  // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = LOAD;
      LOAD:       state_nxt = (n == '0) ? DONE : ACCUM;
      ACCUM:      if (last) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == LOAD) || (state == ACCUM);
    valid = (state == DONE);
  end

  // NOTE: the vector copy is pure data qualified by n, so it carries no reset and can map to plain flops/RAM.
  always_ff @(posedge CLK) begin
    if (accept) vec <= vector1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      n      <= '0;
      idx    <= '0;
      acc    <= '0;
      scalar <= '0;
      count  <= '0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (accept) begin
        n   <= eff_len(length);
        idx <= '0;
        acc <= '0;
      end else if (state == ACCUM) begin
        acc <= acc_sum;
        idx <= idx + 1'b1;
      end
      if (finish) begin
        scalar <= clamp_y;
        ovf    <= clamp_ovf;
        zero   <= (clamp_y == 32'sd0);
        count  <= 32'(n);
      end
    end
  end

endmodule
